forwarding_unit: RTL and testbench



---
 rtl/forwarding_unit_pkg.sv | 23 ++
 rtl/forwarding_unit_if.sv | 63 ++++++
 rtl/forwarding_unit_fwd_select.sv | 41 ++++
 rtl/forwarding_unit.sv | 77 +++++++
 tb/tb_forwarding_unit.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/forwarding_unit_pkg.sv
// Shared types for the EX-stage forwarding unit.
// Defines the operand-mux select codes and a select-counting helper.
package forwarding_unit_pkg;

    // Operand mux select: register file, EX/MEM result, MEM/WB result.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_MW = 2'b01,
        FWD_EM = 2'b10
    } fwd_sel_t;

    // Number of operands (0..2) whose select equals code.
    function automatic logic [1:0] numSel(
        input fwd_sel_t a,
        input fwd_sel_t b,
        input fwd_sel_t code
    );
        logic [1:0] n;
        n = {1'b0, (a == code)} + {1'b0, (b == code)};
        return n;
    endfunction

endpackage

// File: rtl/forwarding_unit_if.sv
// Forwarding unit bus: register specifiers and write enables in, selects out.
// master = pipeline/driver side, slave = forwarding unit. Macro FORWARD_STATS_EN adds counters.
interface forwarding_unit_if #(
    parameter int REG_W = 4
`ifdef FORWARD_STATS_EN
   ,parameter int CNT_W = 16
`endif
);
    logic             EMRegWrite;
    logic             MWRegWrite;
    logic [REG_W-1:0] EMreadReg1;
    logic [REG_W-1:0] EMreadReg2;
    logic [REG_W-1:0] IEreadReg1;
    logic [REG_W-1:0] IEreadReg2;
    logic [REG_W-1:0] MWreadReg1;
    logic [REG_W-1:0] MWreadReg2;
    logic [1:0]       ForwardA;
    logic [1:0]       ForwardB;
    logic [1:0]       ForwardA_q;
    logic [1:0]       ForwardB_q;
`ifdef FORWARD_STATS_EN
    logic [CNT_W-1:0] fwdEMCount;
    logic [CNT_W-1:0] fwdMWCount;

    modport master (
        output EMRegWrite, MWRegWrite,
        output EMreadReg1, EMreadReg2,
        output IEreadReg1, IEreadReg2,
        output MWreadReg1, MWreadReg2,
        input  ForwardA, ForwardB,
        input  ForwardA_q, ForwardB_q,
        input  fwdEMCount, fwdMWCount
    );

    modport slave (
        input  EMRegWrite, MWRegWrite,
        input  EMreadReg1, EMreadReg2,
        input  IEreadReg1, IEreadReg2,
        input  MWreadReg1, MWreadReg2,
        output ForwardA, ForwardB,
        output ForwardA_q, ForwardB_q,
        output fwdEMCount, fwdMWCount
    );
`else
    modport master (
        output EMRegWrite, MWRegWrite,
        output EMreadReg1, EMreadReg2,
        output IEreadReg1, IEreadReg2,
        output MWreadReg1, MWreadReg2,
        input  ForwardA, ForwardB,
        input  ForwardA_q, ForwardB_q
    );

    modport slave (
        input  EMRegWrite, MWRegWrite,
        input  EMreadReg1, EMreadReg2,
        input  IEreadReg1, IEreadReg2,
        input  MWreadReg1, MWreadReg2,
        output ForwardA, ForwardB,
        output ForwardA_q, ForwardB_q
    );
`endif
endinterface

// File: rtl/forwarding_unit_fwd_select.sv
// One-operand forwarding select: compares a source register against both stages.
// Ports: write enables, two dest specifiers per stage, source specifier in; sel out.
module fwd_select
    import forwarding_unit_pkg::*;
#(
    parameter int REG_W      = 4,
    parameter int ZERO_FIXED = 0
) (
    input  logic             emRegWrite,
    input  logic             mwRegWrite,
    input  logic [REG_W-1:0] emDest1,
    input  logic [REG_W-1:0] emDest2,
    input  logic [REG_W-1:0] mwDest1,
    input  logic [REG_W-1:0] mwDest2,
    input  logic [REG_W-1:0] src,
    output fwd_sel_t         sel
);
    logic srcZero;
    logic emHit;
    logic mwHit;

    assign srcZero = (ZERO_FIXED != 0) && (src == '0);

    assign emHit = emRegWrite
                && ((emDest1 == src) || (emDest2 == src))
                && !srcZero;

    assign mwHit = mwRegWrite
                && ((mwDest1 == src) || (mwDest2 == src))
                && !srcZero;

    // Newest producer wins; an unknown EM hit falls through to MW.
    always_comb begin
        sel = FWD_RF;
        if (emHit) begin
            sel = FWD_EM;
        end else if (mwHit) begin
            sel = FWD_MW;
        end
    end
endmodule

// File: rtl/forwarding_unit.sv
// EX-stage bypass select generator: combinational ForwardA/B plus registered copies.
// Ports: clk, rst (async, active-high), bus (slave). FORWARD_STATS_EN adds forward counters.
module forwarding_unit
    import forwarding_unit_pkg::*;
#(
    parameter int REG_W      = 4,
    parameter int ZERO_FIXED = 0
`ifdef FORWARD_STATS_EN
   ,parameter int CNT_W      = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    forwarding_unit_if.slave     bus
);
    fwd_sel_t selA;
    fwd_sel_t selB;

    fwd_select #(.REG_W(REG_W), .ZERO_FIXED(ZERO_FIXED)) uSelA (
        .emRegWrite (bus.EMRegWrite),
        .mwRegWrite (bus.MWRegWrite),
        .emDest1    (bus.EMreadReg1),
        .emDest2    (bus.EMreadReg2),
        .mwDest1    (bus.MWreadReg1),
        .mwDest2    (bus.MWreadReg2),
        .src        (bus.IEreadReg1),
        .sel        (selA)
    );

    fwd_select #(.REG_W(REG_W), .ZERO_FIXED(ZERO_FIXED)) uSelB (
        .emRegWrite (bus.EMRegWrite),
        .mwRegWrite (bus.MWRegWrite),
        .emDest1    (bus.EMreadReg1),
        .emDest2    (bus.EMreadReg2),
        .mwDest1    (bus.MWreadReg1),
        .mwDest2    (bus.MWreadReg2),
        .src        (bus.IEreadReg2),
        .sel        (selB)
    );

    assign bus.ForwardA = selA;
    assign bus.ForwardB = selB;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ForwardA_q <= FWD_RF;
            bus.ForwardB_q <= FWD_RF;
        end else begin
            bus.ForwardA_q <= selA;
            bus.ForwardB_q <= selB;
        end
    end

`ifdef FORWARD_STATS_EN
    logic [1:0]     emInc;
    logic [1:0]     mwInc;
    logic [CNT_W:0] emSum;
    logic [CNT_W:0] mwSum;

    assign emInc = numSel(selA, selB, FWD_EM);
    assign mwInc = numSel(selA, selB, FWD_MW);

    // One extra bit catches the carry so the counters stick at all-ones.
    assign emSum = {1'b0, bus.fwdEMCount} + {{(CNT_W-1){1'b0}}, emInc};
    assign mwSum = {1'b0, bus.fwdMWCount} + {{(CNT_W-1){1'b0}}, mwInc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fwdEMCount <= '0;
            bus.fwdMWCount <= '0;
        end else begin
            bus.fwdEMCount <= emSum[CNT_W] ? '1 : emSum[CNT_W-1:0];
            bus.fwdMWCount <= mwSum[CNT_W] ? '1 : mwSum[CNT_W-1:0];
        end
    end
`endif
endmodule

// File: tb/tb_forwarding_unit.sv
// Self-checking bench for forwarding_unit: directed vectors, random stimulus, async reset.
// Two DUTs share stimulus: ZERO_FIXED=0 (dut) and ZERO_FIXED=1 (dutZ).
module tb_forwarding_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    forwarding_unit_if #(.REG_W(4)) ifA ();
    forwarding_unit_if #(.REG_W(4)) ifZ ();

    forwarding_unit #(.REG_W(4), .ZERO_FIXED(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifA)
    );

    forwarding_unit #(.REG_W(4), .ZERO_FIXED(1)) dutZ (
        .clk (clk),
        .rst (rst),
        .bus (ifZ)
    );

    // Current stimulus, held by the bench so the model can read it.
    bit       wr [2];      // [0]=EX/MEM, [1]=MEM/WB (newest first)
    int       dst [2][2];  // destination specifiers per stage
    int       srcA;
    int       srcB;

    // Reference: walk stages newest-first; first writer holding s supplies it.
    function automatic logic [1:0] model(input int s, input bit zf);
        logic [1:0] codes [2];
        codes[0] = 2'b10;
        codes[1] = 2'b01;
        if (zf && s == 0) return 2'b00;
        for (int st = 0; st < 2; st++) begin
            if (wr[st] && (dst[st][0] == s || dst[st][1] == s))
                return codes[st];
        end
        return 2'b00;
    endfunction

    function automatic logic [3:0] modelAB(input bit zf);
        return {model(srcA, zf), model(srcB, zf)};
    endfunction

    task automatic drive(
        input bit emw, input bit mww,
        input int em1, input int em2,
        input int mw1, input int mw2,
        input int ie1, input int ie2
    );
        wr[0] = emw;  wr[1] = mww;
        dst[0][0] = em1; dst[0][1] = em2;
        dst[1][0] = mw1; dst[1][1] = mw2;
        srcA = ie1; srcB = ie2;
        ifA.EMRegWrite = emw;       ifZ.EMRegWrite = emw;
        ifA.MWRegWrite = mww;       ifZ.MWRegWrite = mww;
        ifA.EMreadReg1 = 4'(em1);   ifZ.EMreadReg1 = 4'(em1);
        ifA.EMreadReg2 = 4'(em2);   ifZ.EMreadReg2 = 4'(em2);
        ifA.MWreadReg1 = 4'(mw1);   ifZ.MWreadReg1 = 4'(mw1);
        ifA.MWreadReg2 = 4'(mw2);   ifZ.MWreadReg2 = 4'(mw2);
        ifA.IEreadReg1 = 4'(ie1);   ifZ.IEreadReg1 = 4'(ie1);
        ifA.IEreadReg2 = 4'(ie2);   ifZ.IEreadReg2 = 4'(ie2);
    endtask

`ifdef FORWARD_STATS_EN
    int emCnt = 0;
    int mwCnt = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            emCnt <= 0;
            mwCnt <= 0;
        end else begin
            emCnt <= emCnt + (model(srcA, 0) == 2'b10) + (model(srcB, 0) == 2'b10);
            mwCnt <= mwCnt + (model(srcA, 0) == 2'b01) + (model(srcB, 0) == 2'b01);
        end
    end
`endif

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ifA.ForwardA_q, ifA.ForwardB_q} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_q got=%b exp=0000", {ifA.ForwardA_q, ifA.ForwardB_q});
        end
        checks++;
        if ({ifA.ForwardA, ifA.ForwardB} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_comb got=%b exp=0000", {ifA.ForwardA, ifA.ForwardB});
        end
`ifdef FORWARD_STATS_EN
        checks++;
        if (ifA.fwdEMCount !== '0 || ifA.fwdMWCount !== '0) begin
            errors++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", ifA.fwdEMCount, ifA.fwdMWCount);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        bit       emw;
        bit       mww;
        logic [3:0] em1, em2, mw1, mw2, ie1, ie2;
        logic [3:0] expAB;
    } vec_t;

    task automatic test_directed();
        vec_t v [10];
        v[0] = '{1, 0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd9, 4'b1000};
        v[1] = '{0, 1, 4'd0, 4'd0, 4'd2, 4'd2, 4'd2, 4'd3, 4'b0100};
        v[2] = '{1, 0, 4'd4, 4'd4, 4'd0, 4'd0, 4'd3, 4'd4, 4'b0010};
        v[3] = '{0, 1, 4'd0, 4'd0, 4'd8, 4'd8, 4'd7, 4'd8, 4'b0001};
        v[4] = '{1, 1, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'b1010};
        v[5] = '{0, 1, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'b0101};
        v[6] = '{0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000};
        v[7] = '{1, 1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b1010};
        v[8] = '{1, 0, 4'd3, 4'd6, 4'd0, 4'd0, 4'd6, 4'd3, 4'b1010};
        v[9] = '{0, 1, 4'd0, 4'd0, 4'd1, 4'd12, 4'd12, 4'd2, 4'b0100};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(v[i].emw, v[i].mww, int'(v[i].em1), int'(v[i].em2),
                  int'(v[i].mw1), int'(v[i].mw2), int'(v[i].ie1), int'(v[i].ie2));
            #1;
            checks++;
            if ({ifA.ForwardA, ifA.ForwardB} !== v[i].expAB) begin
                errors++;
                $display("FAIL dir%0d_comb got=%b exp=%b", i,
                         {ifA.ForwardA, ifA.ForwardB}, v[i].expAB);
            end
            checks++;
            if ({ifZ.ForwardA, ifZ.ForwardB} !== modelAB(1)) begin
                errors++;
                $display("FAIL dir%0d_zero got=%b exp=%b", i,
                         {ifZ.ForwardA, ifZ.ForwardB}, modelAB(1));
            end
            @(posedge clk);
            #1;
            checks++;
            if ({ifA.ForwardA_q, ifA.ForwardB_q} !== v[i].expAB) begin
                errors++;
                $display("FAIL dir%0d_q got=%b exp=%b", i,
                         {ifA.ForwardA_q, ifA.ForwardB_q}, v[i].expAB);
            end
        end
    endtask

    function automatic int pick(input int a, input int b);
        int r;
        r = int'($urandom_range(0, 3));
        if (r == 0) return a;
        if (r == 1) return b;
        return int'($urandom_range(0, 15));
    endfunction

    task automatic test_random();
        int em1, em2, mw1, mw2;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            em1 = int'($urandom_range(0, 15));
            em2 = int'($urandom_range(0, 15));
            mw1 = int'($urandom_range(0, 15));
            mw2 = int'($urandom_range(0, 15));
            drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  em1, em2, mw1, mw2,
                  pick(em1, mw2), pick(mw1, em2));
            #1;
            checks++;
            if ({ifA.ForwardA, ifA.ForwardB} !== modelAB(0)) begin
                errors++;
                $display("FAIL rnd%0d_comb got=%b exp=%b", i,
                         {ifA.ForwardA, ifA.ForwardB}, modelAB(0));
            end
            checks++;
            if ({ifZ.ForwardA, ifZ.ForwardB} !== modelAB(1)) begin
                errors++;
                $display("FAIL rnd%0d_zero got=%b exp=%b", i,
                         {ifZ.ForwardA, ifZ.ForwardB}, modelAB(1));
            end
            @(posedge clk);
            #1;
            checks++;
            if ({ifA.ForwardA_q, ifA.ForwardB_q} !== modelAB(0)) begin
                errors++;
                $display("FAIL rnd%0d_q got=%b exp=%b", i,
                         {ifA.ForwardA_q, ifA.ForwardB_q}, modelAB(0));
            end
`ifdef FORWARD_STATS_EN
            checks++;
            if (int'(ifA.fwdEMCount) != emCnt || int'(ifA.fwdMWCount) != mwCnt) begin
                errors++;
                $display("FAIL rnd%0d_cnt got=%0d/%0d exp=%0d/%0d", i,
                         ifA.fwdEMCount, ifA.fwdMWCount, emCnt, mwCnt);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(1, 1, 7, 7, 9, 9, 7, 9);
        @(posedge clk);
        #1;
        checks++;
        if ({ifA.ForwardA_q, ifA.ForwardB_q} !== 4'b1001) begin
            errors++;
            $display("FAIL arst_pre got=%b exp=1001", {ifA.ForwardA_q, ifA.ForwardB_q});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ifA.ForwardA_q, ifA.ForwardB_q} !== 4'b0000) begin
            errors++;
            $display("FAIL arst_q got=%b exp=0000", {ifA.ForwardA_q, ifA.ForwardB_q});
        end
        checks++;
        if ({ifA.ForwardA, ifA.ForwardB} !== 4'b1001) begin
            errors++;
            $display("FAIL arst_comb got=%b exp=1001", {ifA.ForwardA, ifA.ForwardB});
        end
`ifdef FORWARD_STATS_EN
        checks++;
        if (ifA.fwdEMCount !== '0 || ifA.fwdMWCount !== '0) begin
            errors++;
            $display("FAIL arst_cnt got=%0d/%0d exp=0/0", ifA.fwdEMCount, ifA.fwdMWCount);
        end
`endif
        @(posedge clk);
        #1;
        checks++;
        if ({ifA.ForwardA_q, ifA.ForwardB_q} !== 4'b0000) begin
            errors++;
            $display("FAIL arst_hold got=%b exp=0000", {ifA.ForwardA_q, ifA.ForwardB_q});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({ifA.ForwardA_q, ifA.ForwardB_q} !== 4'b1001) begin
            errors++;
            $display("FAIL arst_post got=%b exp=1001", {ifA.ForwardA_q, ifA.ForwardB_q});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
